// File: rtl/upsample2x_engine.sv
// upsample2x_engine: 2x upsampler, IN_WIDTH^2 signed 8-bit raster in, (2*IN_WIDTH)^2 raster out.
// Latency: input accept to first copy on pixel_out is 1 cycle; 1 output/cycle, input taken 1 of 4 cycles.
// Backpressure: one output register; it holds while valid_out && !ready_out and ready_in drops.
// Build option: define UPSAMPLE_ZERO_INSERT_EN for zero-insertion unpool instead of replication.
module upsample2x_engine #(
  parameter int IN_WIDTH  = 14,
  parameter int OUT_WIDTH = 2 * IN_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  output logic       ready_in,
  input  logic [7:0] pixel_in,
  output logic       valid_out,
  input  logic       ready_out,
  output logic [7:0] pixel_out,
  output logic       all_done
);

  localparam int COL_W    = $clog2(IN_WIDTH);
  localparam int CNT_W    = $clog2(OUT_WIDTH * OUT_WIDTH) + 1;
  localparam int OUT_LAST = OUT_WIDTH * OUT_WIDTH - 1;

`ifdef UPSAMPLE_ZERO_INSERT_EN
  localparam bit ZERO_INSERT = 1'b1;
`else
  localparam bit ZERO_INSERT = 1'b0;
`endif

  typedef enum logic {S_EVEN, S_ODD} state_t;

  state_t             state, state_nxt;
  logic [COL_W-1:0]   col, col_nxt;
  logic [COL_W-1:0]   in_row, row_nxt;
  logic               phase, phase_nxt;
  logic [7:0]         hold, hold_nxt;
  logic [7:0]         pix_nxt;
  logic               vld_nxt;
  logic               done_nxt;
  logic [CNT_W-1:0]   out_cnt, cnt_nxt;
  logic               buf_we;
  logic               slot_free, in_xfer, out_xfer;
  logic               col_last, row_last;
  logic [7:0]         line_buf [IN_WIDTH];

  // Handshake terms: the output register can take a new value when empty or draining this cycle.
  always_comb begin
    slot_free = !valid_out || ready_out;
    ready_in  = !rst && (state == S_EVEN) && !phase && slot_free;
    in_xfer   = valid_in && ready_in;
    out_xfer  = valid_out && ready_out;
    col_last  = (col == COL_W'(IN_WIDTH - 1));
    row_last  = (in_row == COL_W'(IN_WIDTH - 1));
  end

  // Next-state and output-register logic for the even/odd output row FSM.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = in_row;
    phase_nxt = phase;
    hold_nxt  = hold;
    pix_nxt   = pixel_out;
    vld_nxt   = slot_free ? 1'b0 : valid_out;
    buf_we    = 1'b0;

    unique case (state)
      S_EVEN: begin
        if (in_xfer) begin
          // First copy goes straight out; the second copy and the odd row come from storage.
          pix_nxt   = pixel_in;
          vld_nxt   = 1'b1;
          hold_nxt  = pixel_in;
          buf_we    = !ZERO_INSERT;
          phase_nxt = 1'b1;
        end else if (phase && slot_free) begin
          pix_nxt   = ZERO_INSERT ? 8'd0 : hold;
          vld_nxt   = 1'b1;
          phase_nxt = 1'b0;
          if (col_last) begin
            col_nxt   = '0;
            state_nxt = S_ODD;
          end else begin
            col_nxt = col + 1'b1;
          end
        end
      end
      S_ODD: begin
        if (slot_free) begin
          pix_nxt   = ZERO_INSERT ? 8'd0 : line_buf[col];
          vld_nxt   = 1'b1;
          phase_nxt = !phase;
          if (phase) begin
            if (col_last) begin
              col_nxt   = '0;
              state_nxt = S_EVEN;
              row_nxt   = row_last ? '0 : in_row + 1'b1;
            end else begin
              col_nxt = col + 1'b1;
            end
          end
        end
      end
      default: state_nxt = S_EVEN;
    endcase
  end

  // Frame completion tracking: count output transfers; completion wins over a same-cycle accept.
  always_comb begin
    cnt_nxt  = out_cnt;
    done_nxt = all_done;
    if (out_xfer) begin
      if (out_cnt == CNT_W'(OUT_LAST)) begin
        cnt_nxt = '0;
      end else begin
        cnt_nxt = out_cnt + 1'b1;
      end
    end
    if (out_xfer && (out_cnt == CNT_W'(OUT_LAST))) begin
      done_nxt = 1'b1;
    end else if (in_xfer) begin
      done_nxt = 1'b0;
    end
  end

  // State register with synchronous reset; a reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EVEN;
      col       <= '0;
      in_row    <= '0;
      phase     <= 1'b0;
      hold      <= 8'd0;
      pixel_out <= 8'd0;
      valid_out <= 1'b0;
      out_cnt   <= '0;
      all_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      in_row    <= row_nxt;
      phase     <= phase_nxt;
      hold      <= hold_nxt;
      pixel_out <= pix_nxt;
      valid_out <= vld_nxt;
      out_cnt   <= cnt_nxt;
      all_done  <= done_nxt;
    end
  end

  // Line buffer keeps the even row for replay on the odd row; contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[col] <= pixel_in;
    end
  end

endmodule

// File: tb/tb_upsample2x_engine.sv
module tb_upsample2x_engine;
  localparam int W = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] pixel_in;
  logic       valid_out;
  logic       ready_out;
  logic [7:0] pixel_out;
  logic       all_done;

  logic [7:0] src_q[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_v[16];
  int         acc_cnt;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  upsample2x_engine #(.IN_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .pixel_in  (pixel_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .pixel_out (pixel_out),
    .all_done  (all_done)
  );

  // Upstream source: presents the head of src_q, updated just after each rising edge.
  initial begin
    valid_in = 1'b0;
    pixel_in = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (src_q.size() > 0) begin
        valid_in = 1'b1;
        pixel_in = src_q[0];
      end else begin
        valid_in = 1'b0;
        pixel_in = 8'd0;
      end
    end
  end

  // Monitor on the falling edge: records transfers that happen at the next rising edge.
  initial begin
    acc_cnt = 0;
    forever begin
      @(negedge clk);
      if (valid_out && ready_out) out_q.push_back(pixel_out);
      if (valid_in && ready_in) begin
        acc_cnt++;
        void'(src_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_out(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (out_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      sample();
    end
  endtask

  // Hand-derived output frame for a 2x2 input a,b / c,d.
  task automatic set_exp(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
`ifdef UPSAMPLE_ZERO_INSERT_EN
    exp_v = '{a, 8'd0, b, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
              c, 8'd0, d, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`else
    exp_v = '{a, a, b, b, a, a, b, b, c, c, d, d, c, c, d, d};
`endif
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    src_q.push_back(a);
    src_q.push_back(b);
    src_q.push_back(c);
    src_q.push_back(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_out = 1'b1;
    step();
    step();
    sample();
    checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b want 0", valid_out); else passed++;
    checks++; if (pixel_out !== 8'd0) $display("FAIL reset_pixel_out: got %h want 00", pixel_out); else passed++;
    checks++; if (all_done !== 1'b0) $display("FAIL reset_all_done: got %b want 0", all_done); else passed++;
    checks++; if (ready_in !== 1'b0) $display("FAIL reset_ready_in: got %b want 0", ready_in); else passed++;
    step();
    rst = 1'b0;
    sample();
    checks++; if (ready_in !== 1'b1) $display("FAIL reset_release_ready_in: got %b want 1", ready_in); else passed++;
  endtask

  task automatic test_basic();
    bit ok;
    out_q.delete();
    set_exp(8'd1, 8'd2, 8'd3, 8'd4);
    push4(8'd1, 8'd2, 8'd3, 8'd4);
    wait_out(16, ok);
    checks++; if (!ok) $display("FAIL basic_timeout: got %0d outputs want 16", out_q.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp_v[i])
        $display("FAIL basic_out[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp_v[i]);
      else passed++;
    end
    sample();
    checks++; if (all_done !== 1'b1) $display("FAIL basic_all_done: got %b want 1", all_done); else passed++;
  endtask

  task automatic test_stall();
    bit ok;
    logic [7:0] held;
    held = 8'd0;
    out_q.delete();
    set_exp(8'd1, 8'd2, 8'd3, 8'd4);
    push4(8'd1, 8'd2, 8'd3, 8'd4);
    wait_out(2, ok);
    checks++; if (!ok) $display("FAIL stall_start_timeout: got %0d outputs want 2", out_q.size()); else passed++;
    step();
    ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      if (k == 0) begin
        held = pixel_out;
        checks++; if (pixel_out !== 8'd2) $display("FAIL stall_pixel: got %h want 02", pixel_out); else passed++;
      end else begin
        checks++; if (pixel_out !== held) $display("FAIL stall_hold[%0d]: got %h want %h", k, pixel_out, held); else passed++;
      end
      checks++; if (valid_out !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", k, valid_out); else passed++;
      checks++; if (ready_in !== 1'b0) $display("FAIL stall_ready_in[%0d]: got %b want 0", k, ready_in); else passed++;
    end
    step();
    ready_out = 1'b1;
    wait_out(16, ok);
    checks++; if (!ok) $display("FAIL stall_timeout: got %0d outputs want 16", out_q.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp_v[i])
        $display("FAIL stall_out[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp_v[i]);
      else passed++;
    end
    sample();
  endtask

  task automatic test_signed();
    bit ok;
    out_q.delete();
    set_exp(8'h80, 8'h7F, 8'hFF, 8'h00);
    push4(8'h80, 8'h7F, 8'hFF, 8'h00);
    wait_out(16, ok);
    checks++; if (!ok) $display("FAIL signed_timeout: got %0d outputs want 16", out_q.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp_v[i])
        $display("FAIL signed_out[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp_v[i]);
      else passed++;
    end
    sample();
  endtask

  task automatic test_rst_mid_frame();
    bit ok;
    out_q.delete();
    push4(8'd1, 8'd2, 8'd3, 8'd4);
    // Six outputs recorded means the even row is done and the odd row is being replayed.
    wait_out(6, ok);
    checks++; if (!ok) $display("FAIL rstmid_start_timeout: got %0d outputs want 6", out_q.size()); else passed++;
    step();
    rst = 1'b1;
    src_q.delete();
    sample();
    sample();
    checks++; if (valid_out !== 1'b0) $display("FAIL rstmid_valid_out: got %b want 0", valid_out); else passed++;
    checks++; if (all_done !== 1'b0) $display("FAIL rstmid_all_done: got %b want 0", all_done); else passed++;
    out_q.delete();
    step();
    rst = 1'b0;
    set_exp(8'd5, 8'd6, 8'd7, 8'd8);
    push4(8'd5, 8'd6, 8'd7, 8'd8);
    sample();
    checks++; if (ready_in !== 1'b1) $display("FAIL rstmid_ready_in: got %b want 1", ready_in); else passed++;
    wait_out(16, ok);
    checks++; if (!ok) $display("FAIL rstmid_timeout: got %0d outputs want 16", out_q.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp_v[i])
        $display("FAIL rstmid_out[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp_v[i]);
      else passed++;
    end
    sample();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int a0;
    bit seen;
    checks++; if (all_done !== 1'b1) $display("FAIL b2b_done_before: got %b want 1", all_done); else passed++;
    out_q.delete();
    a0 = acc_cnt;
    push4(8'd9, 8'd10, 8'd11, 8'd12);
    push4(8'd13, 8'd14, 8'd15, 8'd16);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      sample();
      if (acc_cnt > a0) begin
        seen = 1'b1;
        break;
      end
    end
    checks++; if (!seen) $display("FAIL b2b_accept_timeout: got %0d accepts want 1", acc_cnt - a0); else passed++;
    sample();
    checks++; if (all_done !== 1'b0) $display("FAIL b2b_done_cleared: got %b want 0", all_done); else passed++;
    wait_out(32, ok);
    checks++; if (!ok) $display("FAIL b2b_timeout: got %0d outputs want 32", out_q.size()); else passed++;
    set_exp(8'd9, 8'd10, 8'd11, 8'd12);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= out_q.size() || out_q[i] !== exp_v[i])
        $display("FAIL b2b_f1_out[%0d]: got %h want %h", i, (i < out_q.size()) ? out_q[i] : 8'hxx, exp_v[i]);
      else passed++;
    end
    set_exp(8'd13, 8'd14, 8'd15, 8'd16);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (16 + i >= out_q.size() || out_q[16 + i] !== exp_v[i])
        $display("FAIL b2b_f2_out[%0d]: got %h want %h", i, (16 + i < out_q.size()) ? out_q[16 + i] : 8'hxx, exp_v[i]);
      else passed++;
    end
    sample();
    checks++; if (all_done !== 1'b1) $display("FAIL b2b_done_after: got %b want 1", all_done); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    ready_out = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_signed();
    test_rst_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
